// File: rtl/paddle_ctrl.sv
// Right-paddle position controller: button sync/debounce, movement tick, clamped position stepping.
// Optional hold-to-accelerate behaviour is built when PADDLE_ACCEL_EN is defined.
module paddle_ctrl #(
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned PADDLE_H     = 40,
  parameter int unsigned START_Y      = 220,
  parameter int unsigned STEP         = 4,
  parameter int unsigned TICK_DIV     = 250000,
  parameter int unsigned DEBOUNCE_CYC = 65536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] paddle_y,
  output logic       move_tick,
  output logic       moving
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned SW = 5;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [9:0]    Y_MAX     = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]    Y_RST     = 10'(START_Y);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [1:0]    up_sync_q, dn_sync_q;
  logic          du_q, du_d, dd_q, dd_d;
  logic [DW-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          move_tick_q, move_tick_d;
  logic [1:0]    state_q, state_d;
  logic          moving_q, moving_d;
  logic [9:0]    paddle_y_q, paddle_y_d;
  logic [SW-1:0] step;
  logic signed [10:0] y_up, y_dn;

  // Debounce: accept the synced level only after DEBOUNCE_CYC consecutive differing samples
  always_comb begin
    du_d     = du_q;
    dd_d     = dd_q;
    up_cnt_d = '0;
    dn_cnt_d = '0;
    if (up_sync_q[1] != du_q) begin
      if (up_cnt_q == DEB_LAST) du_d = up_sync_q[1];
      else                      up_cnt_d = up_cnt_q + DW'(1);
    end
    if (dn_sync_q[1] != dd_q) begin
      if (dn_cnt_q == DEB_LAST) dd_d = dn_sync_q[1];
      else                      dn_cnt_d = dn_cnt_q + DW'(1);
    end
  end

  // Free-running tick divider and next-state decode
  always_comb begin
    tick_cnt_d  = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    move_tick_d = (tick_cnt_q == TICK_LAST);
    state_d     = ST_IDLE;
    if (du_q && !dd_q)      state_d = ST_UP;
    else if (dd_q && !du_q) state_d = ST_DOWN;
    moving_d = (state_d != ST_IDLE);
  end

`ifdef PADDLE_ACCEL_EN
  logic [3:0] hold_q, hold_d;

  // Count ticks spent in one direction; a full count doubles the step
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_IDLE || state_d != state_q) hold_d = '0;
    else if (move_tick_q && hold_q != 4'd8)       hold_d = hold_q + 4'd1;
    step = (hold_q == 4'd8) ? SW'(2 * STEP) : SW'(STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`else
  assign step = SW'(STEP);
`endif

  // Widened signed arithmetic so neither limit can wrap before clamping
  assign y_up = $signed({1'b0, paddle_y_q}) - $signed(11'(step));
  assign y_dn = $signed({1'b0, paddle_y_q}) + $signed(11'(step));

  always_comb begin
    paddle_y_d = paddle_y_q;
    if (move_tick_q) begin
      case (state_q)
        ST_UP:   paddle_y_d = (y_up < 11'sd0) ? 10'd0 : y_up[9:0];
        ST_DOWN: paddle_y_d = (y_dn > $signed({1'b0, Y_MAX})) ? Y_MAX : y_dn[9:0];
        default: paddle_y_d = paddle_y_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_sync_q   <= '0;
      dn_sync_q   <= '0;
      du_q        <= 1'b0;
      dd_q        <= 1'b0;
      up_cnt_q    <= '0;
      dn_cnt_q    <= '0;
      tick_cnt_q  <= '0;
      move_tick_q <= 1'b0;
      state_q     <= ST_IDLE;
      moving_q    <= 1'b0;
      paddle_y_q  <= Y_RST;
    end else begin
      up_sync_q   <= {up_sync_q[0], btn_up};
      dn_sync_q   <= {dn_sync_q[0], btn_down};
      du_q        <= du_d;
      dd_q        <= dd_d;
      up_cnt_q    <= up_cnt_d;
      dn_cnt_q    <= dn_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      move_tick_q <= move_tick_d;
      state_q     <= state_d;
      moving_q    <= moving_d;
      paddle_y_q  <= paddle_y_d;
    end
  end

  assign paddle_y  = paddle_y_q;
  assign move_tick = move_tick_q;
  assign moving    = moving_q;

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Right-paddle position controller that drives the paddle-position input of the ball stage. Synchronises and debounces two raw push-buttons, generates a movement tick, and steps a clamped 10-bit paddle position once per tick. The output holds the paddle top edge in screen pixels; the hit window spans `paddle_y` .. `paddle_y + PADDLE_H - 1`.

## Interface
- `SCREEN_H`, default 480: visible lines.
- `PADDLE_H`, default 40: paddle height in pixels.
- `START_Y`, default 220: reset position of the paddle top edge.
- `STEP`, default 4: pixels moved per tick (1..15).
- `TICK_DIV`, default 250000: clock cycles per movement tick (≥2).
- `DEBOUNCE_CYC`, default 65536: consecutive identical samples needed to accept a button level (≥1).
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_up` in 1: raw, asynchronous, active-high up button.
- `btn_down` in 1: raw, asynchronous, active-high down button.
- `paddle_y` out 10: paddle top edge, 0..SCREEN_H-PADDLE_H.
- `move_tick` out 1: one-cycle pulse on each movement tick.
- `moving` out 1: high while the FSM is in UP or DOWN.

## Operation
- Reset values:
  - `paddle_y` = START_Y; `move_tick` = 0; `moving` = 0.
  - Synchroniser flops, debounced levels, and debounce counters = 0.
  - Tick counter = 0; FSM = IDLE; hold counter = 0.
- Synchroniser: each button passes through a 2-flop chain.
- Debounce, per button:
  - Counter clears whenever the synced sample equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYC-1 while still differing, the debounced level takes the sample and the counter clears.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - `move_tick` is registered high for exactly the cycle after the counter equals TICK_DIV-1.
- FSM states: IDLE, UP, DOWN. Evaluated on every cycle from the debounced levels `du` and `dd`:
  - `du & ~dd` → UP.
  - `dd & ~du` → DOWN.
  - Both or neither → IDLE.
  - A direct reversal UP↔DOWN is allowed in one cycle.
- Position update, only in a cycle where `move_tick` = 1:
  - UP: `paddle_y` ← max(0, `paddle_y` − step).
  - DOWN: `paddle_y` ← min(SCREEN_H−PADDLE_H, `paddle_y` + step).
  - IDLE: hold.
- Arithmetic is done in 11 bits signed-safe before clamping, so no wrap-around occurs at 0 or at the bottom limit.
- At a limit, `paddle_y` stays at the limit. The FSM remains in UP/DOWN and `moving` stays 1.
- `moving` = (state != IDLE), registered.

## Timing
- Button edge to synced: 2 cycles.
- Synced to debounced: DEBOUNCE_CYC cycles of stable level.
- Debounced to FSM state: 1 cycle.
- State to position change: effective at the first `move_tick` cycle after the state is entered. `paddle_y` is updated on the clock edge ending that tick cycle.
- A state change coinciding with a tick cycle uses the state registered in that cycle, not the new state.
- A glitch shorter than DEBOUNCE_CYC cycles never changes the debounced level.
- `reset_n` asserted mid-operation: all outputs go to reset values immediately, asynchronously. Deassertion is synchronised externally; the first tick follows TICK_DIV cycles after release.

## Configuration
- `PADDLE_ACCEL_EN` defined:
  - A 4-bit hold counter counts consecutive ticks spent in the same non-IDLE state, saturating at 8.
  - While the counter equals 8, step = 2×STEP; otherwise step = STEP.
  - The counter clears on any state change or on IDLE.
  - Clamping rules are unchanged.
- Undefined: step is always STEP; no hold counter is built.

## Test plan
Run with TICK_DIV=4, DEBOUNCE_CYC=3, STEP=4, START_Y=220 unless stated.
- Reset:
  - Stimulus: assert `reset_n`=0 mid-run.
  - Response: `paddle_y`=220, `move_tick`=0, `moving`=0 in the same cycle, without waiting for a clock edge.
- Debounce:
  - Stimulus: 2-cycle pulse on `btn_up`.
  - Response: no state change and `paddle_y` stays 220.
  - Stimulus: hold `btn_up` high.
  - Response: `moving`=1 within 2+3+1 cycles; then `paddle_y` reads 216, 212, … on successive ticks.
- Top clamp:
  - Stimulus: START_Y=6, hold up.
  - Response: `paddle_y` 6 → 2 → 0, then stays 0 with `moving`=1.
- Bottom clamp:
  - Stimulus: START_Y=436, hold down.
  - Response: `paddle_y` 436 → 440 and stays 440 (SCREEN_H−PADDLE_H).
- Conflicting buttons:
  - Stimulus: both buttons held.
  - Response: IDLE, `moving`=0, `paddle_y` constant across 10 ticks.
  - Stimulus: release up.
  - Response: DOWN; position increments by 4 per tick.
- Acceleration (`PADDLE_ACCEL_EN`):
  - Stimulus: hold down from 100.
  - Response: first 8 ticks step by 4, reaching 132; subsequent ticks step by 8 (140, 148, …).
  - Stimulus: a brief release long enough to reach IDLE.
  - Response: step returns to 4.
